// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the
// baud divisor helper used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line, idling high,
// with a registered previous value for falling-edge (start) detection.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Shift the line through the synchronizer and remember the last synced value
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], rx_i};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign rx_s = sync_r[STAGES-1];
    assign fall = prev_r & ~sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM with a valid/ready output
// register, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic                 rx_sync_s;
    logic                 fall_s;
    rx_state_t            state_r;
    logic [CW-1:0]        cnt_r;
    logic [2:0]           idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [7:0]           data_r;
    logic                 valid_r;
    logic                 ferr_r;
    logic                 ovr_r;
    logic                 busy_r;

    uart_rx_sync #(.STAGES(2)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx_i (rx_i),
        .rx_s (rx_sync_s),
        .fall (fall_s)
    );

    // Receive FSM, baud/bit counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= '0;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ferr_r <= 1'b0;
            ovr_r  <= 1'b0;
            if (valid_r && ready_i) begin
                valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        cnt_r   <= '0;
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= '0;
                        // A line back high at mid-start was only a glitch
                        if (rx_sync_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= DATA;
                            idx_r   <= 3'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r          <= '0;
                        shift_r[idx_r] <= rx_sync_s;
                        idx_r          <= idx_r + 3'd1;
                        if (idx_r == IDX_LAST) begin
                            state_r <= STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        if (!rx_sync_s) begin
                            ferr_r <= 1'b1;
                        end else if (!valid_r || ready_i) begin
                            // A load in the same cycle as an accept overrides the clear
                            data_r  <= shift_r;
                            valid_r <= 1'b1;
                        end else begin
                            ovr_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign frame_err_o = ferr_r;
    assign overrun_o   = ovr_r;
    assign busy_o      = busy_r;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of `uart_tx` on the UART link. It samples the asynchronous serial line, recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop), and presents each byte on a valid/ready handshake to the parallel side. It flags framing errors and overruns. Together with `uart_tx` it forms the loopback pair used in system simulation.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `CLKS_PER_BIT`, default CLK_FREQ/BAUD (868): derived, integer-truncated. Must be ≥ 4; elaboration fails otherwise.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset is synchronous and active-high.
- `rx_i`, input, 1: asynchronous serial line; idles high.
- `data_o`, output, 8: received byte; stable while `valid_o` is high.
- `valid_o`, output, 1: byte available.
- `ready_i`, input, 1: consumer accepts the byte when `valid_o && ready_i` at a rising edge.
- `frame_err_o`, output, 1: one-cycle pulse when the stop bit samples 0.
- `overrun_o`, output, 1: one-cycle pulse when a good frame completes while `valid_o` is still high.
- `busy_o`, output, 1: high in any state other than IDLE.

## Operation
- **Synchronizer.** `rx_i` passes through a 2-FF synchronizer to produce `rx_s`. Both flops reset to 1. A start condition is `rx_s` = 0 with the previous `rx_s` = 1 (falling edge).
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE.** On a falling edge, clear the baud counter and go to START.
- **START.** Count HALF = CLKS_PER_BIT/2 cycles, then sample `rx_s`.
  - If `rx_s` = 1, treat it as a glitch and return to IDLE with no flags.
  - If `rx_s` = 0, go to DATA with bit index 0.
- **DATA.** Count CLKS_PER_BIT cycles, sample `rx_s` into shift register bit [index], and increment the index. After index 7 is sampled, go to STOP.
- **STOP.** Count CLKS_PER_BIT cycles, sample `rx_s`, then handle the result and return to IDLE:
  - Stop = 1 and `valid_o` = 0: load `data_o`, set `valid_o`.
  - Stop = 1 and `valid_o` = 1 (unconsumed): pulse `overrun_o`. The new byte is dropped; `data_o` is unchanged.
  - Stop = 0: pulse `frame_err_o`. The byte is discarded and `valid_o` is unchanged.
- **Re-arming.** IDLE re-arms only on a new falling edge, so a line held low (break) produces exactly one `frame_err_o` and nothing more until the line returns high.
- **Handshake.** `valid_o` clears on the cycle after `valid_o && ready_i`. If a load and an accept happen in the same cycle, the load wins: `valid_o` stays 1 and `data_o` takes the new byte, with no overrun.
- **Counters.**
  - Baud counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 on each sample.
  - Bit index is 3 bits wide.
- **Reset.** `rst` takes effect at any time, including mid-frame. The FSM goes to IDLE, counters are cleared, and the frame in progress is abandoned.

## Timing
- Reset values: `data_o` = 8'h00, `valid_o` = 0, `frame_err_o` = 0, `overrun_o` = 0, `busy_o` = 0, synchronizer flops = 1.
- rx_s lags `rx_i` by 2 cycles.
- Let t0 be the cycle at which the FSM leaves IDLE (rx_s first low). Each sample occurs at the end of its count:
  - start sample: t0 + HALF
  - data bit k: t0 + HALF + (k+1)·CLKS_PER_BIT
  - stop bit: t0 + HALF + 9·CLKS_PER_BIT
- `valid_o`, `frame_err_o` and `overrun_o` are registered. They assert in the cycle after the stop sample.
- `busy_o` is 1 from t0+1 through the stop sample.
- The FSM is back in IDLE one cycle after the stop sample. Back-to-back frames, with the next start edge arriving at half a bit into the stop bit or later, are received without loss.
- Baud tolerance: the mid-bit sampling error over 10 bits stays within ±½ bit for a rate mismatch of ≤ 4%.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP).
  - `DATA_BITS` = 8.
  - function `clks_per_bit(clk_freq, baud)`, reused by `uart_tx`.
- Sub-module `uart_rx_sync`: parameterised 2-FF synchronizer with reset value 1, plus falling-edge detect. Outputs `rx_s` and `fall`.
- The FSM, counters, shift register and output register live in `uart_rx`.

## Test plan
All scenarios use CLK_FREQ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10), with `rst` held high for 5 cycles.
- **Basic frame.** Drive 0x55 with `ready_i` = 1 → exactly one `valid_o` pulse with `data_o` = 0x55, `valid_o` rising at t0+96 (HALF + 9·CLKS_PER_BIT + 1), and no flags.
- **Overrun.** Hold `ready_i` = 0, send 0xA3 then 0x0F back-to-back → `data_o` = 0xA3 with `valid_o` held; one `overrun_o` pulse at the end of the second frame. Then raise `ready_i` → `valid_o` drops the next cycle.
- **Framing error and break.** Send 0x3C with stop bit = 0 → one `frame_err_o` pulse and `valid_o` stays 0. Then hold `rx_i` low for 300 cycles → exactly one further `frame_err_o` and no activity until the line goes high.
- **Glitch rejection.** Pulse `rx_i` low for 3 cycles → `busy_o` rises, returns to IDLE at t0+5, and no outputs pulse. A following 0xF0 frame is received correctly.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 4 of 0x81 → all outputs at reset values. A subsequent 0x7E frame is received correctly.
- **Loopback.** Connect `uart_tx` (same parameters) `data_o` to `rx_i`. Send 0x00, 0xFF, 0x5A → all three bytes received in order, no flags.
